// File: rtl/irq_sequencer.sv
// irq_sequencer: edge-detecting, masked, fixed-priority interrupt sequencer that drives the return-address stack.
// Define IRQ_NESTING_EN to allow higher-priority preemption with an internal saved-id stack.
module irq_sequencer #(
  parameter int unsigned N_IRQ      = 4,
  parameter logic [9:0]  VEC_BASE   = 10'h3F0,
  parameter int unsigned VEC_STRIDE = 4,
  parameter int unsigned MAX_NEST   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             reti,
  input  logic             stk_overflow,
  input  logic             stk_underflow,
  output logic             push,
  output logic             pop,
  output logic             interrupt,
  output logic             vec_take,
  output logic             ret_take,
  output logic [9:0]       vec_addr,
  output logic [2:0]       active_id,
  output logic             busy,
  output logic             fault
);

  localparam int unsigned DEPTH_W = $clog2(MAX_NEST + 1);
`ifdef IRQ_NESTING_EN
  localparam int unsigned IDX_W = (MAX_NEST > 1) ? $clog2(MAX_NEST) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_SERVICE = 3'd2,
    S_RETURN  = 3'd3,
    S_FAULT   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [N_IRQ-1:0]     irq_q, rise_q, pending_q, pending_d, mask_q, mask_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [2:0]           active_id_q, active_id_d;
  logic                 push_q, push_d, pop_q, pop_d, intr_q, intr_d;
  logic                 vtake_q, vtake_d, rtake_q, rtake_d, busy_q, busy_d, fault_q, fault_d;
  logic [9:0]           vec_q, vec_d;
  logic [N_IRQ-1:0]     eligible;
  logic [2:0]           winner;
  logic                 has_win;
`ifdef IRQ_NESTING_EN
  logic [2:0]           id_stk_q [MAX_NEST];
  logic [2:0]           id_stk_d [MAX_NEST];
`endif

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    eligible = pending_q & mask_q;
    has_win  = |eligible;
    winner   = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | rise_q;
    mask_d      = mask_we ? mask_in : mask_q;
    depth_d     = depth_q;
    active_id_d = active_id_q;
`ifdef IRQ_NESTING_EN
    id_stk_d    = id_stk_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (has_win) begin
          active_id_d = winner;
          state_d     = S_ENTER;
        end
      end
      S_ENTER: begin
        // A fresh rise on the line being entered re-arms it.
        pending_d = (pending_q & ~(N_IRQ'(1) << active_id_q)) | rise_q;
        depth_d   = depth_q + DEPTH_W'(1);
        state_d   = stk_overflow ? S_FAULT : S_SERVICE;
      end
      S_SERVICE: begin
        if (reti) begin
          state_d = S_RETURN;
        end
`ifdef IRQ_NESTING_EN
        else if (has_win && (winner < active_id_q) && (depth_q < DEPTH_W'(MAX_NEST))) begin
          id_stk_d[IDX_W'(depth_q - DEPTH_W'(1))] = active_id_q;
          active_id_d = winner;
          state_d     = S_ENTER;
        end
`endif
      end
      S_RETURN: begin
        depth_d = depth_q - DEPTH_W'(1);
        if (stk_underflow) begin
          state_d = S_FAULT;
        end else if (depth_d == '0) begin
          state_d     = S_IDLE;
          active_id_d = '0;
        end else begin
          state_d = S_SERVICE;
`ifdef IRQ_NESTING_EN
          active_id_d = id_stk_q[IDX_W'(depth_q - DEPTH_W'(2))];
`endif
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered as a function of the next state so they align with it.
    push_d  = (state_d == S_ENTER);
    vtake_d = (state_d == S_ENTER);
    pop_d   = (state_d == S_RETURN);
    rtake_d = (state_d == S_RETURN);
    intr_d  = (state_d == S_ENTER) || (state_d == S_RETURN);
    busy_d  = (state_d != S_IDLE);
    fault_d = (state_d == S_FAULT);
    vec_d   = (state_d == S_ENTER) ? VEC_BASE + 10'(32'(active_id_d) * VEC_STRIDE) : '0;
  end

  always_ff @(posedge clk) begin
    irq_q <= irq;
    if (!reset) begin
      state_q     <= S_IDLE;
      rise_q      <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      depth_q     <= '0;
      active_id_q <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      intr_q      <= 1'b0;
      vtake_q     <= 1'b0;
      rtake_q     <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      vec_q       <= '0;
`ifdef IRQ_NESTING_EN
      id_stk_q    <= '{default: '0};
`endif
    end else begin
      state_q     <= state_d;
      rise_q      <= irq & ~irq_q;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      depth_q     <= depth_d;
      active_id_q <= active_id_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      intr_q      <= intr_d;
      vtake_q     <= vtake_d;
      rtake_q     <= rtake_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
      vec_q       <= vec_d;
`ifdef IRQ_NESTING_EN
      id_stk_q    <= id_stk_d;
`endif
    end
  end

  assign push      = push_q;
  assign pop       = pop_q;
  assign interrupt = intr_q;
  assign vec_take  = vtake_q;
  assign ret_take  = rtake_q;
  assign vec_addr  = vec_q;
  assign active_id = active_id_q;
  assign busy      = busy_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: vector table, hand-written corner sequences and randomized waves.
module tb_irq_sequencer;

  logic       clk = 1'b0;
  logic       reset, mask_we, reti, ovf, unf;
  logic [3:0] irq, mask_in;
  logic       push, pop, interrupt, vec_take, ret_take, busy, fault;
  logic [9:0] vec_addr;
  logic [2:0] active_id;
  logic [6:0] flg;

  always #5 clk = ~clk;

  irq_sequencer dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .reti(reti), .stk_overflow(ovf), .stk_underflow(unf),
    .push(push), .pop(pop), .interrupt(interrupt), .vec_take(vec_take),
    .ret_take(ret_take), .vec_addr(vec_addr), .active_id(active_id),
    .busy(busy), .fault(fault)
  );

  assign flg = {push, pop, interrupt, vec_take, ret_take, busy, fault};

  // Flag order: push pop interrupt vec_take ret_take busy fault
  localparam logic [6:0] F_IDL = 7'b0000000;
  localparam logic [6:0] F_ENT = 7'b1011010;
  localparam logic [6:0] F_SRV = 7'b0000010;
  localparam logic [6:0] F_RET = 7'b0110110;
  localparam logic [6:0] F_FLT = 7'b0000011;

  typedef struct packed {
    logic [3:0] irq;
    logic       we;
    logic [3:0] min;
    logic       reti;
    logic [6:0] flags;
    logic [9:0] vec;
    logic [2:0] id;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [3:0] i, input logic w, input logic [3:0] m,
                              input logic r, input logic [6:0] f, input logic [9:0] v,
                              input logic [2:0] id);
    vec_t t;
    t = '{irq: i, we: w, min: m, reti: r, flags: f, vec: v, id: id};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_push(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (push) got = 1'b1;
    end
  endtask

  task automatic count_push(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c += int'(push);
    end
  endtask

  task automatic pulse(input logic [3:0] m);
    irq = m;
    @(negedge clk);
    irq = 4'b0000;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_in = m;
    @(negedge clk);
    mask_we = 1'b0;
  endtask

  // Expect entry of line id, service it for a few cycles, then return.
  task automatic serve(input int id, input string tag);
    bit got;
    wait_push(12, got);
    chk({tag, "_enter"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_id"}, 32'(active_id), 32'(id));
      chk({tag, "_vec"}, 32'(vec_addr), 32'(10'h3F0 + 10'(id * 4)));
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    chk({tag, "_pop"}, 32'({pop, ret_take}), 32'b11);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         got;
    int         c;
    logic [3:0] m, s;
    int         q[$];

    tbl.push_back(mk(4'h0, 1, 4'hF, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h4, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_ENT, 10'h3F8, 3'd2));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_SRV, 10'h000, 3'd2));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, F_RET, 10'h000, 3'd2));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'hA, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_ENT, 10'h3F4, 3'd1));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_SRV, 10'h000, 3'd1));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, F_RET, 10'h000, 3'd1));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_ENT, 10'h3FC, 3'd3));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_SRV, 10'h000, 3'd3));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, F_RET, 10'h000, 3'd3));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 1, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h1, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 1, 4'h1, 0, F_IDL, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_ENT, 10'h3F0, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_SRV, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, F_RET, 10'h000, 3'd0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, F_IDL, 10'h000, 3'd0));

    reset = 1'b0; irq = 4'b0001; mask_we = 1'b0; mask_in = 4'h0;
    reti = 1'b0; ovf = 1'b0; unf = 1'b0;

    // A line held high through reset must not count as an edge.
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({flg, vec_addr, active_id}), 32'd0);
    reset = 1'b1;
    write_mask(4'hF);
    count_push(6, c);
    chk("rst_no_enter", 32'(c), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    irq = 4'b0000;
    count_push(4, c);
    chk("fall_no_enter", 32'(c), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      irq     = tbl[i].irq;
      mask_we = tbl[i].we;
      mask_in = tbl[i].min;
      reti    = tbl[i].reti;
      @(negedge clk);
      chk($sformatf("tbl[%0d]", i), 32'({flg, vec_addr, active_id}),
          32'({tbl[i].flags, tbl[i].vec, tbl[i].id}));
    end
    irq = 4'h0; mask_we = 1'b0; reti = 1'b0;

    // Same line rising again during its ENTER cycle stays pending.
    write_mask(4'hF);
    irq = 4'b0100;
    @(negedge clk);
    irq = 4'b0000;
    @(negedge clk);
    irq = 4'b0100;
    @(negedge clk);
    irq = 4'b0000;
    chk("rerise_enter", 32'({flg, vec_addr, active_id}), 32'({F_ENT, 10'h3F8, 3'd2}));
    @(negedge clk);
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    chk("rerise_pop", 32'(pop), 32'd1);
    serve(2, "rerise_again");

    // Higher-priority request while servicing line 2.
    pulse(4'b0100);
    wait_push(12, got);
    chk("pre_enter2", 32'({got, active_id}), 32'({1'b1, 3'd2}));
    @(negedge clk);
    pulse(4'b0001);
`ifdef IRQ_NESTING_EN
    wait_push(12, got);
    chk("nest_enter0", 32'({got, vec_addr, active_id}), 32'({1'b1, 10'h3F0, 3'd0}));
    @(negedge clk);
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    chk("nest_ret1", 32'({pop, active_id}), 32'({1'b1, 3'd0}));
    @(negedge clk);
    chk("nest_back_to_2", 32'({flg, active_id}), 32'({F_SRV, 3'd2}));
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    chk("nest_ret2", 32'({pop, active_id}), 32'({1'b1, 3'd2}));
    @(negedge clk);
    chk("nest_idle", 32'(flg), 32'(F_IDL));
`else
    count_push(8, c);
    chk("no_preempt", 32'(c), 32'd0);
    chk("no_preempt_state", 32'({busy, active_id}), 32'({1'b1, 3'd2}));
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    chk("no_preempt_pop", 32'(pop), 32'd1);
    serve(0, "after_ret");
`endif

    // Overflow during ENTER: sticky fault, no later stack activity.
    pulse(4'b0010);
    wait_push(12, got);
    chk("ovf_enter", 32'(got), 32'd1);
    ovf = 1'b1;
    @(negedge clk);
    ovf = 1'b0;
    chk("ovf_fault", 32'(flg), 32'(F_FLT));
    reti = 1'b1;
    irq  = 4'b0001;
    @(negedge clk);
    reti = 1'b0;
    irq  = 4'b0000;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      c += int'(pop) + int'(push) + int'(vec_take) + int'(ret_take);
    end
    chk("fault_no_stack_ops", 32'(c), 32'd0);
    chk("fault_sticky", 32'(flg), 32'(F_FLT));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("fault_reset", 32'({flg, vec_addr, active_id}), 32'd0);

    // Underflow during RETURN.
    write_mask(4'hF);
    pulse(4'b1000);
    wait_push(12, got);
    chk("unf_enter", 32'({got, active_id}), 32'({1'b1, 3'd3}));
    @(negedge clk);
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    chk("unf_pop", 32'(pop), 32'd1);
    unf = 1'b1;
    @(negedge clk);
    unf = 1'b0;
    chk("unf_fault", 32'(flg), 32'(F_FLT));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Reset during ENTER aborts and clears the request.
    write_mask(4'hF);
    pulse(4'b0001);
    wait_push(12, got);
    chk("rst_mid_enter_push", 32'(got), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_mid_enter", 32'(flg), 32'(F_IDL));
    write_mask(4'hF);
    count_push(6, c);
    chk("rst_abort_no_push", 32'(c), 32'd0);

    // Random waves: a set of lines rises together under a random mask.
    for (int t = 0; t < 30; t++) begin
      m = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(1, 15));
      write_mask(m);
      pulse(s);
      q.delete();
      for (int i = 0; i < 4; i++) if (s[i] && m[i]) q.push_back(i);
      foreach (q[j]) serve(q[j], "rnd");
      if ((s & ~m) != 4'h0) begin
        count_push(8, c);
        chk("rnd_masked_quiet", 32'(c), 32'd0);
        write_mask(4'hF);
        q.delete();
        for (int i = 0; i < 4; i++) if (s[i] && !m[i]) q.push_back(i);
        foreach (q[j]) serve(q[j], "rnd_late");
      end
    end
    count_push(6, c);
    chk("rnd_final_quiet", 32'({c, busy}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
